// File: rtl/pwm_run_sequencer_if.sv
// Control/status bundle between the register block and the PWM run sequencer.
// Sequencer side is the slave; the control-register side is the master.
interface pwm_run_sequencer_if #(
  parameter int N_CARR = 8
);
  logic              start;
  logic              stop;
  logic              fault;
  logic              fault_clr;
  logic [N_CARR-1:0] ch_enable;
  logic [N_CARR-1:0] maskevent;
  logic [15:0]       stop_timeout;
  logic [N_CARR-1:0] pwm_onoff;
  logic [1:0]        run_state;
  logic              busy;
  logic              done_pulse;
  logic              timeout_flag;
  logic              fault_latched;

  modport master (
    output start, stop, fault, fault_clr, ch_enable, maskevent, stop_timeout,
    input  pwm_onoff, run_state, busy, done_pulse, timeout_flag, fault_latched
  );

  modport slave (
    input  start, stop, fault, fault_clr, ch_enable, maskevent, stop_timeout,
    output pwm_onoff, run_state, busy, done_pulse, timeout_flag, fault_latched
  );
endinterface

// File: rtl/pwm_run_sequencer.sv
// Run/stop sequencer driving per-carrier pwm_onoff; start turns all enabled carriers on together.
// All outputs registered, fault latency 1; no backpressure, stop waits on per-channel mask events.
module pwm_run_sequencer #(
  parameter int N_CARR     = 8,
  parameter int ARM_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pwm_run_sequencer_if.slave   bus
);

  localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t            r_state,   w_state;
  logic [N_CARR-1:0] r_en_q,    w_en_q;
  logic [N_CARR-1:0] r_pending, w_pending;
  logic [N_CARR-1:0] r_pwm,     w_pwm;
  logic [AW-1:0]     r_arm_cnt, w_arm_cnt;
  logic [15:0]       r_to_cnt,  w_to_cnt;
  logic              r_done,    w_done;
  logic              r_tflag,   w_tflag;
  logic              r_flat,    w_flat;
  logic [N_CARR-1:0] w_pend_left;

  always_comb begin
    w_state     = r_state;
    w_en_q      = r_en_q;
    w_pending   = r_pending;
    w_pwm       = r_pwm;
    w_arm_cnt   = r_arm_cnt;
    w_to_cnt    = r_to_cnt;
    w_done      = 1'b0;
    w_tflag     = r_tflag;
    w_flat      = r_flat;
    w_pend_left = r_pending & ~bus.maskevent;

    if (bus.fault_clr && !bus.fault) begin
      w_flat = 1'b0;
    end

    if (bus.fault) begin
      w_state   = S_IDLE;
      w_pwm     = '0;
      w_pending = '0;
      w_arm_cnt = '0;
      w_to_cnt  = '0;
      w_flat    = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && (|bus.ch_enable) && !r_flat) begin
            w_en_q    = bus.ch_enable;
            w_arm_cnt = ARM_LOAD;
            w_tflag   = 1'b0;
            w_state   = S_ARM;
          end
        end
        S_ARM: begin
          if (bus.stop) begin
            w_state   = S_IDLE;
            w_arm_cnt = '0;
            w_done    = 1'b1;
          end else if (r_arm_cnt == '0) begin
            w_pwm   = r_en_q;
            w_state = S_RUN;
          end else begin
            w_arm_cnt = r_arm_cnt - AW'(1);
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            w_pending = r_pwm;
            w_to_cnt  = bus.stop_timeout;
            w_state   = S_STOP;
          end
        end
        S_STOP: begin
          w_pending = w_pend_left;
          w_pwm     = r_pwm & ~(r_pending & bus.maskevent);
          if (r_to_cnt != 16'd0) begin
            w_to_cnt = r_to_cnt - 16'd1;
          end
          // A last mask event coinciding with expiry is treated as graceful.
          if (w_pend_left == '0) begin
            w_state  = S_IDLE;
            w_to_cnt = '0;
            w_done   = 1'b1;
          end else if (r_to_cnt == 16'd1) begin
            w_pwm     = '0;
            w_pending = '0;
            w_tflag   = 1'b1;
            w_state   = S_IDLE;
            w_done    = 1'b1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_en_q    <= '0;
      r_pending <= '0;
      r_pwm     <= '0;
      r_arm_cnt <= '0;
      r_to_cnt  <= '0;
      r_done    <= 1'b0;
      r_tflag   <= 1'b0;
      r_flat    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_en_q    <= w_en_q;
      r_pending <= w_pending;
      r_pwm     <= w_pwm;
      r_arm_cnt <= w_arm_cnt;
      r_to_cnt  <= w_to_cnt;
      r_done    <= w_done;
      r_tflag   <= w_tflag;
      r_flat    <= w_flat;
    end
  end

  assign bus.pwm_onoff     = r_pwm;
  assign bus.run_state     = r_state;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done_pulse    = r_done;
  assign bus.timeout_flag  = r_tflag;
  assign bus.fault_latched = r_flat;

endmodule

// File: tb/tb_pwm_run_sequencer.sv
// Randomized and directed bench for pwm_run_sequencer against a cycle-count reference model.
module tb_pwm_run_sequencer;

  localparam int N  = 8;
  localparam int AC = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pwm_run_sequencer_if #(.N_CARR(N)) bus ();

  pwm_run_sequencer #(.N_CARR(N), .ARM_CYCLES(AC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: absolute cycle deadlines instead of down-counters.
  int       cyc;
  int       m_mode;      // 0 idle, 1 arm, 2 run, 3 stop
  int       m_on_at;
  int       m_to_at;
  logic [N-1:0] m_en, m_pwm, m_pend;
  logic     m_done, m_tflag, m_flat;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic old_flat;
    cyc++;
    m_done = 1'b0;
    if (!reset) begin
      m_mode = 0; m_en = '0; m_pwm = '0; m_pend = '0;
      m_tflag = 1'b0; m_flat = 1'b0; m_on_at = 0; m_to_at = 0;
      return;
    end
    old_flat = m_flat;
    if (bus.fault_clr && !bus.fault) m_flat = 1'b0;
    if (bus.fault) begin
      m_mode = 0; m_pwm = '0; m_pend = '0; m_flat = 1'b1;
      return;
    end
    case (m_mode)
      0: if (bus.start && bus.ch_enable != 0 && !old_flat) begin
           m_en = bus.ch_enable; m_mode = 1; m_on_at = cyc + AC; m_tflag = 1'b0;
         end
      1: if (bus.stop) begin
           m_mode = 0; m_done = 1'b1;
         end else if (cyc == m_on_at) begin
           m_pwm = m_en; m_mode = 2;
         end
      2: if (bus.stop) begin
           m_pend = m_pwm; m_mode = 3;
           m_to_at = (bus.stop_timeout != 0) ? cyc + int'(bus.stop_timeout) : 0;
         end
      default: begin
        m_pend = m_pend & ~bus.maskevent;
        m_pwm  = m_pend;
        if (m_pend == 0) begin
          m_mode = 0; m_done = 1'b1;
        end else if (cyc == m_to_at) begin
          m_pwm = '0; m_pend = '0; m_tflag = 1'b1; m_mode = 0; m_done = 1'b1;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("pwm",   int'(bus.pwm_onoff),     int'(m_pwm));
    chk("state", int'(bus.run_state),     m_mode);
    chk("busy",  int'(bus.busy),          int'(m_mode != 0));
    chk("done",  int'(bus.done_pulse),    int'(m_done));
    chk("tflag", int'(bus.timeout_flag),  int'(m_tflag));
    chk("flat",  int'(bus.fault_latched), int'(m_flat));
    bus.start = 1'b0; bus.stop = 1'b0; bus.fault = 1'b0;
    bus.fault_clr = 1'b0; bus.maskevent = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_run(input logic [N-1:0] en);
    bus.ch_enable = en; bus.start = 1'b1;
    tick();
    ticks(AC);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    m_mode = 0; m_en = '0; m_pwm = '0; m_pend = '0;
    m_tflag = 1'b0; m_flat = 1'b0; m_on_at = 0; m_to_at = 0; m_done = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    bus.ch_enable = '0; bus.maskevent = '0; bus.stop_timeout = '0;
    ticks(2);
    chk("rst_pwm", int'(bus.pwm_onoff), 0);
    chk("rst_state", int'(bus.run_state), 0);
    reset = 1'b1;
    tick();

    // Basic run
    bus.ch_enable = 8'h0F; bus.start = 1'b1;
    tick();
    chk("arm_entry", int'(bus.run_state), 1);
    ticks(AC - 1);
    chk("arm_pwm_off", int'(bus.pwm_onoff), 0);
    tick();
    chk("run_pwm", int'(bus.pwm_onoff), 'h0F);
    chk("run_busy", int'(bus.busy), 1);

    // Graceful stop
    bus.stop = 1'b1; tick();
    chk("stop_entry", int'(bus.run_state), 3);
    tick();
    bus.maskevent = 8'h01; tick();
    chk("gs_0e", int'(bus.pwm_onoff), 'h0E);
    bus.maskevent = 8'h06; tick();
    chk("gs_08", int'(bus.pwm_onoff), 'h08);
    tick();
    bus.maskevent = 8'h08; tick();
    chk("gs_00", int'(bus.pwm_onoff), 0);
    chk("gs_done", int'(bus.done_pulse), 1);
    chk("gs_tflag", int'(bus.timeout_flag), 0);
    tick();
    chk("gs_done_once", int'(bus.done_pulse), 0);

    // Timeout
    bus.stop_timeout = 16'd10;
    start_run(8'h03);
    bus.stop = 1'b1; tick();
    bus.maskevent = 8'h01; tick();
    chk("to_02", int'(bus.pwm_onoff), 'h02);
    ticks(8);
    chk("to_hold", int'(bus.pwm_onoff), 'h02);
    tick();
    chk("to_off", int'(bus.pwm_onoff), 0);
    chk("to_flag", int'(bus.timeout_flag), 1);
    chk("to_done", int'(bus.done_pulse), 1);

    // Fault
    start_run(8'hFF);
    chk("f_run", int'(bus.pwm_onoff), 'hFF);
    bus.fault = 1'b1; tick();
    chk("f_pwm", int'(bus.pwm_onoff), 0);
    chk("f_latched", int'(bus.fault_latched), 1);
    chk("f_nodone", int'(bus.done_pulse), 0);
    bus.start = 1'b1; tick();
    chk("f_start_ign", int'(bus.run_state), 0);
    bus.fault = 1'b1; bus.fault_clr = 1'b1; tick();
    chk("f_clr_blocked", int'(bus.fault_latched), 1);
    bus.fault_clr = 1'b1; tick();
    chk("f_clr", int'(bus.fault_latched), 0);
    bus.start = 1'b1; tick();
    chk("f_restart", int'(bus.run_state), 1);

    // Stop during ARM
    bus.stop = 1'b1; tick();
    chk("arm_stop_idle", int'(bus.run_state), 0);
    chk("arm_stop_done", int'(bus.done_pulse), 1);
    chk("arm_stop_pwm", int'(bus.pwm_onoff), 0);

    // start+stop in IDLE, then zero-enable start
    bus.start = 1'b1; bus.stop = 1'b1; tick();
    chk("ss_arm", int'(bus.run_state), 1);
    bus.stop = 1'b1; tick();
    bus.ch_enable = '0; bus.start = 1'b1; tick();
    chk("zero_en", int'(bus.run_state), 0);

    // Reset mid-STOP
    bus.stop_timeout = 16'd0;
    start_run(8'h05);
    bus.stop = 1'b1; tick();
    chk("rs_pwm_pre", int'(bus.pwm_onoff), 'h05);
    reset = 1'b0; tick();
    chk("rs_pwm", int'(bus.pwm_onoff), 0);
    chk("rs_state", int'(bus.run_state), 0);
    chk("rs_tflag", int'(bus.timeout_flag), 0);
    chk("rs_flat", int'(bus.fault_latched), 0);
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset            = ($urandom_range(0, 499) != 0);
      bus.start        = ($urandom_range(0, 3) == 0);
      bus.stop         = ($urandom_range(0, 15) == 0);
      bus.fault        = ($urandom_range(0, 79) == 0);
      bus.fault_clr    = ($urandom_range(0, 7) == 0);
      bus.ch_enable    = N'($urandom) & N'($urandom | $urandom);
      bus.maskevent    = N'($urandom) & N'($urandom) & N'($urandom);
      bus.stop_timeout = 16'($urandom_range(0, 20));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_run_sequencer.md
# pwm_run_sequencer

Run/stop sequencer for the 8-carrier PWM array. Generates the per-channel `pwm_onoff` enables for the `carrier_16bits_1carr` instances:
- On start, all enabled carriers switch on in the same cycle.
- On stop, each carrier switches off only at its own mask event, so its period ends cleanly.
- A stop timeout and a latched fault path force all carriers off.

It sits between the AXI control registers and the carrier instances.

## Interface
Parameters:
- `N_CARR`, 8, number of carrier channels controlled.
- `ARM_CYCLES`, 4, cycles spent in ARM before enabling (≥1); lets the masked config registers settle.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle start request.
- `stop` in 1: one-cycle graceful stop request.
- `fault` in 1: level; any high cycle kills all outputs.
- `fault_clr` in 1: one-cycle clear of `fault_latched`.
- `ch_enable` in N_CARR: channels to run; sampled on start acceptance.
- `maskevent` in N_CARR: per-channel mask event from each carrier block.
- `stop_timeout` in 16: STOP-state limit in clk cycles; 0 disables the timeout.
- `pwm_onoff` out N_CARR: per-channel enable to the carrier blocks.
- `run_state` out 2: IDLE=0, ARM=1, RUN=2, STOP=3.
- `busy` out 1: `run_state` != IDLE.
- `done_pulse` out 1: one-cycle pulse on a graceful or timeout return to IDLE.
- `timeout_flag` out 1: sticky; the last stop ended by timeout.
- `fault_latched` out 1: sticky fault indicator.

## Operation
- Reset (`reset`=0 at a clk edge): every output is 0, state is IDLE, internal `en_q`, `pending` and counters are 0.
- Priority in every state: `fault` > `stop` > `start`.
- fault:
  - If `fault`=1 in any state, next cycle gives `pwm_onoff`=0, state IDLE, `fault_latched`=1, and no `done_pulse`.
  - `fault_latched` clears on `fault_clr`=1 only while `fault`=0.
- IDLE:
  - `start`=1 with `ch_enable`≠0 and `fault_latched`=0 is accepted.
  - On acceptance: `en_q`←`ch_enable`, arm counter ←ARM_CYCLES−1, `timeout_flag`←0, go to ARM.
  - Otherwise `start` is ignored.
  - `stop` in IDLE is ignored.
- ARM:
  - Arm counter decrements each cycle. At 0: `pwm_onoff`←`en_q` (all bits in the same cycle), go to RUN.
  - `stop` in ARM returns to IDLE with `pwm_onoff` never asserted, and `done_pulse`=1.
- RUN:
  - `pwm_onoff` holds. `start` is ignored.
  - On `stop`: `pending`←`pwm_onoff`, timeout counter ←`stop_timeout`, go to STOP.
- STOP:
  - Each cycle, for each bit i with `pending[i]`=1 and `maskevent[i]`=1, clear `pwm_onoff[i]` and `pending[i]`.
  - `maskevent` on the cycle `stop` is accepted is not considered.
  - When `pending` becomes 0: IDLE with `done_pulse`=1.
  - Timeout counter (only when `stop_timeout`≠0) decrements each STOP cycle. If it reaches 0 with `pending`≠0, that cycle sets `pwm_onoff`←0, `pending`←0, `timeout_flag`←1, state IDLE, `done_pulse`=1.
  - If the last `maskevent` and the timeout expiry land in the same cycle, the stop counts as graceful: `timeout_flag` stays 0.
  - `start` and `stop` are ignored in STOP.
- `maskevent` bits for channels not pending are ignored.
- `ch_enable` changes after acceptance have no effect until the next start.

## Timing
- All outputs are registered. `busy` and `run_state` are derived from the state register.
- `start` at edge t puts `run_state`=ARM at t+1 and `pwm_onoff`=`en_q` at t+ARM_CYCLES+1.
- `stop` at edge t in RUN puts `run_state`=STOP at t+1.
- `maskevent[i]` at edge t in STOP clears `pwm_onoff[i]` at t+1.
- `done_pulse` is high for exactly the one cycle in which `run_state` first reads IDLE.
- `fault` at edge t clears all `pwm_onoff` at t+1; latency 1 from any state.
- A timeout with `stop_timeout`=K expires on the K-th STOP cycle; outputs are off at entry+K.
- `reset`=0 mid-operation clears all outputs at the next edge, regardless of state.

## Test plan
- Basic run:
  - ARM_CYCLES=4, `ch_enable`=0x0F, `start` at t → ARM at t+1.
  - `pwm_onoff`=0x0F at t+5, all 4 bits in one cycle; `busy`=1.
- Graceful stop:
  - From RUN 0x0F, `stop`, then `maskevent` 0x01, 0x06, 0x08 on separate later cycles.
  - `pwm_onoff` steps 0x0E, 0x08, 0x00, each one cycle after its event.
  - `done_pulse` with IDLE; `timeout_flag`=0.
- Timeout:
  - `stop_timeout`=10, RUN 0x03, only `maskevent`=0x01 arrives.
  - `pwm_onoff`=0x02 until the 10th STOP cycle, then 0x00.
  - `timeout_flag`=1 and `done_pulse`=1 at the same edge.
- Fault:
  - `fault` for 1 cycle during RUN 0xFF → next cycle `pwm_onoff`=0, IDLE, `fault_latched`=1, no `done_pulse`.
  - `start` is then ignored.
  - After `fault_clr`, `start` is accepted again.
- Corner cases:
  - `start`+`stop` together in IDLE → ARM.
  - `stop` during ARM → IDLE, `done_pulse`, `pwm_onoff` never nonzero.
  - `start` with `ch_enable`=0 → stays IDLE.
  - `fault_clr` while `fault`=1 → `fault_latched` stays 1.
- Reset mid-STOP:
  - `reset`=0 one cycle with `pwm_onoff`=0x05 → all outputs 0 and IDLE at the next edge.
  - `timeout_flag`=0 and `fault_latched`=0.
